child_resp_collector: RTL and testbench

CHILD_RESP_COLLECTOR -- requirements
Module: child_resp_collector

---
 rtl/child_resp_collector.sv | 70 +++++++
 tb/tb_child_resp_collector.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/child_resp_collector.sv
// child_resp_collector: round-robin merge of N child request channels into one registered output slot.
module child_resp_collector #(
    parameter int N  = 15,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [3:0]      out_idx,
    input  logic            out_ready,
    output logic [15:0]     xfer_cnt
);
    typedef enum logic {EMPTY, FULL} state_e;
    state_e state_q, state_d;
    logic [3:0] last_q, last_d, idx_q, idx_d, gnt_idx;
    logic [DW-1:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0] c;
    logic [N-1:0] sh;
    logic found, free, take;
    // scan starts one past the last granted channel and wraps modulo N
    always_comb begin
        found = 1'b0;
        gnt_idx = '0;
        c = '0;
        sh = '0;
        for (int k = 1; k <= N; k++) begin
            c = 5'(last_q) + 5'(k);
            if (c >= 5'(N)) c = c - 5'(N);
            sh = in_valid >> c;
            if (!found && sh[0]) begin
                found = 1'b1;
                gnt_idx = c[3:0];
            end
        end
    end
    always_comb begin
        free = (state_q == EMPTY) || out_ready;
        take = free && found;
        in_ready = (rst_n && take) ? (N'(1) << gnt_idx) : '0;
        state_d = free ? (found ? FULL : EMPTY) : state_q;
        last_d = take ? gnt_idx : last_q;
        idx_d = take ? gnt_idx : idx_q;
        data_d = take ? DW'(in_data >> (32'(gnt_idx) * DW)) : data_q;
        cnt_d = cnt_q + 16'((state_q == FULL) && out_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q <= 4'(N - 1);
            idx_q <= '0;
            data_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            idx_q <= idx_d;
            data_q <= data_d;
            cnt_q <= cnt_d;
        end
    end
    assign out_valid = (state_q == FULL);
    assign out_data = data_q;
    assign out_idx = idx_q;
    assign xfer_cnt = cnt_q;
endmodule

// File: tb/tb_child_resp_collector.sv
// tb_child_resp_collector: directed and random checks against a per-cycle round-robin reference model.
module tb_child_resp_collector;
    localparam int N = 15, DW = 8;
    logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic [N-1:0] in_valid = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0] in_ready;
    logic out_valid;
    logic [DW-1:0] out_data;
    logic [3:0] out_idx;
    logic [15:0] xfer_cnt;
    int vectors = 0, miscompares = 0;
    int m_valid, m_data, m_idx, m_last, m_cnt;

    child_resp_collector #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic rnd_data();
        in_data = (N*DW)'({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    // one clock: inputs are already driven just after a falling edge
    task automatic cyc(input bit chk);
        int g;
        bit free;
        logic [31:0] er;
        #1;
        free = !m_valid || out_ready;
        g = free ? pick(in_valid, m_last) : -1;
        er = (g >= 0) ? (32'd1 << g) : 32'd0;
        if (chk) check("in_ready", 32'(in_ready), er);
        if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 65536;
        if (free) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data = int'(in_data[g*DW +: DW]);
                m_idx = g;
                m_last = g;
            end else m_valid = 0;
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check("out_valid", 32'(out_valid), m_valid);
            check("xfer_cnt", 32'(xfer_cnt), m_cnt);
            if (m_valid) begin
                check("out_data", 32'(out_data), m_data);
                check("out_idx", 32'(out_idx), m_idx);
            end
        end
        @(negedge clk);
    endtask

    // asserts reset off-edge, checks outputs clear at once, releases on a falling edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_valid = 0; m_data = 0; m_idx = 0; m_cnt = 0; m_last = N - 1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        in_valid = '1; out_ready = 1'b1; rnd_data();
        for (int i = 0; i < N; i++) begin
            cyc(1);
            check("rr_seq_idx", 32'(out_idx), i);
        end
        in_valid = '0;
        cyc(1);
        check("rr_seq_cnt", 32'(xfer_cnt), 15);

        do_reset();
        rnd_data();
        in_data[3*DW +: DW] = 8'hA5;
        in_valid = N'(1) << 3; out_ready = 1'b0;
        cyc(1);
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'hA5);
        check("stall_idx", 32'(out_idx), 3);
        repeat (10) begin
            cyc(1);
            check("hold_data", 32'(out_data), 32'hA5);
            check("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1; in_valid = '0;
        cyc(1);
        check("stall_cnt", 32'(xfer_cnt), 1);
        check("stall_drained", 32'(out_valid), 0);

        do_reset();
        rnd_data(); out_ready = 1'b1;
        in_valid = N'(1) << 5;
        cyc(1);
        in_valid = (N'(1) << 2) | (N'(1) << 9);
        cyc(1);
        check("rr_after5_first", 32'(out_idx), 9);
        cyc(1);
        check("rr_after5_second", 32'(out_idx), 2);

        do_reset();
        rnd_data(); out_ready = 1'b1;
        in_valid = N'(1) << 14;
        cyc(1);
        in_valid = N'(1) | (N'(1) << 14);
        cyc(1);
        check("wrap_idx", 32'(out_idx), 0);

        do_reset();
        repeat (400) begin
            in_valid = N'($urandom());
            if ($urandom_range(0, 3) == 0) in_valid = '0;
            rnd_data();
            out_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        in_valid = N'(1) << 7; out_ready = 1'b0; rnd_data();
        cyc(1);
        check("pre_rst_valid", 32'(out_valid), 1);
        in_valid = N'(1) | (N'(1) << 14);
        do_reset();
        out_ready = 1'b1;
        cyc(1);
        check("post_rst_idx", 32'(out_idx), 0);

        do_reset();
        in_valid = '1; out_ready = 1'b1; rnd_data();
        repeat (65536) cyc(0);
        check("cnt_max", 32'(xfer_cnt), 32'hFFFF);
        cyc(1);
        check("cnt_wrap", 32'(xfer_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
